arrow_neuron_main: RTL and testbench
====================================

# arrow_neuron_main

Single-layer template-matching classifier that recognises one of eight arrow glyphs in a 16×16 binary image. Each of eight neurons scores the registered image against a fixed ±1 weight template, and a winner-take-all stage drives a one-hot class output. The block is the top of the arrow-recognition datapath. A pixel vector is presented from the image source, and the one-hot result goes to downstream display or decision logic.

## Interface
- Parameters: none; image size and class count are fixed constants in the package.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pixel_vector` input 256: image, row-major. Row r occupies bits [255-16r -: 16]. The MSB of each row is column 0 (leftmost). 1 = pixel set.
- `neuron_out` output 8: one-hot class, registered.
  - Bit 0 UP, bit 1 UPLEFT, bit 2 LEFTDOWN, bit 3 LEFT.
  - Bit 4 DOWN, bit 5 UPRIGHT, bit 6 DOWNRIGHT, bit 7 RIGHT.

## Operation
- Templates: 16 rows top→bottom, 16-bit hex per row.
  - UP: 0000 0000 0100 0380 07C0 0FE0 1FF0 0100 0100 0100 0100 0100 0100 0100 0000 0000
  - UPLEFT: 0000 0000 3F80 3F00 3E00 3C00 3A00 3100 2080 0040 0020 0010 0008 0004 0000 0000
  - LEFTDOWN: 0000 0000 0004 0008 0010 0020 0040 2080 3100 3A00 3C00 3E00 3F00 3F80 0000 0000
  - LEFT: 0000 0000 0000 0200 0600 0E00 1E00 3FFC 1E00 0E00 0600 0200 0000 0000 0000 0000
  - DOWN: 0000 0000 0100 0100 0100 0100 0100 0100 0100 1FF0 0FE0 07C0 0380 0100 0000 0000
  - UPRIGHT: 0000 0000 01FC 00FC 007C 003C 005C 008C 0104 0200 0400 0800 1000 2000 0000 0000
  - DOWNRIGHT: 0000 0000 2000 1000 0800 0400 0200 0104 008C 005C 003C 007C 00FC 01FC 0000 0000
  - RIGHT: 0000 0000 0000 0040 0060 0070 0078 3FFC 0078 0070 0060 0040 0000 0000 0000 0000
- Neuron k score:
  - score_k = popcount(pix & T_k) − popcount(pix & ~T_k).
  - Signed 10-bit, range −256..+256, no saturation needed.
- Winner: maximum score. Ties resolve to the lowest index.
- `neuron_out` is exactly one-hot, except when zeroed under the condition in Configuration.

## Timing
- Stage 1, edge N: `pixel_vector` is registered.
- Stage 2, edge N+1: eight scores are registered.
- Stage 3, edge N+2: argmax one-hot is registered into `neuron_out`.
- Latency is 3 rising edges from sampling. The result is stable within 30 ns at a 10 ns clock.
- Fully pipelined: a new image is accepted every cycle. There is no handshake.
- Reset clears all pipeline registers and `neuron_out` to 8'h00.
  - After reset deasserts, the output reflects input sampled after deassertion, at the 3-edge latency.
  - Reset asserted mid-stream discards in-flight images.

## Configuration
- `ARROW_REJECT_EN`:
  - Defined: if the winning score ≤ 0, `neuron_out` = 8'h00 (reject).
  - Undefined: the output is always one-hot argmax, e.g. an all-zero image → 8'h01.

## Structure
- Package `arrow_pkg` holds:
  - IMG_W=16, NUM_PIX=256, NUM_CLASSES=8, SCORE_W=10.
  - The class-index constants.
  - The 8×256 template constant array.
- One sub-module, `arrow_neuron`: template as input, combinational score output. Instantiated eight times.
- Argmax and the pipeline registers live in the top.

## Test plan
- Each of the 8 templates applied for 5 cycles → `neuron_out` = 1<<k after 3 edges. Example: RIGHT → 8'h80.
- Templates changed every cycle → outputs follow in order with 3-cycle latency, no bubbles.
- All-zero image:
  - With ARROW_REJECT_EN → 8'h00.
  - Without it → 8'h01 (all-tie, lowest index).
- UP template with one extra stray pixel at row 0, column 0 → still 8'h01.
- `rst` asserted while a LEFT image is in flight → 8'h00 on the next edge. After release, the output resumes only for images sampled after release.
- All-ones image: scores are equal to 2·|T_k| − 256. Expected results:
  - With ARROW_REJECT_EN → 8'h00.
  - Without it → the one-hot of the largest template.

Source files
------------

// File: rtl/arrow_neuron_main_pkg.sv
// Shared constants for the arrow glyph classifier: geometry, class indices, templates.
package arrow_pkg;

  localparam int unsigned IMG_W       = 16;
  localparam int unsigned NUM_PIX     = 256;
  localparam int unsigned NUM_CLASSES = 8;
  localparam int unsigned SCORE_W     = 10;
  localparam int unsigned CNT_W       = 9;
  localparam int unsigned IDX_W       = 3;

  localparam int unsigned CLS_UP        = 0;
  localparam int unsigned CLS_UPLEFT    = 1;
  localparam int unsigned CLS_LEFTDOWN  = 2;
  localparam int unsigned CLS_LEFT      = 3;
  localparam int unsigned CLS_DOWN      = 4;
  localparam int unsigned CLS_UPRIGHT   = 5;
  localparam int unsigned CLS_DOWNRIGHT = 6;
  localparam int unsigned CLS_RIGHT     = 7;

  // Row 0 sits in the top 16 bits; each row's MSB is the leftmost column.
  localparam logic [NUM_PIX-1:0] T_UP =
    256'h0000_0000_0100_0380_07C0_0FE0_1FF0_0100_0100_0100_0100_0100_0100_0100_0000_0000;
  localparam logic [NUM_PIX-1:0] T_UPLEFT =
    256'h0000_0000_3F80_3F00_3E00_3C00_3A00_3100_2080_0040_0020_0010_0008_0004_0000_0000;
  localparam logic [NUM_PIX-1:0] T_LEFTDOWN =
    256'h0000_0000_0004_0008_0010_0020_0040_2080_3100_3A00_3C00_3E00_3F00_3F80_0000_0000;
  localparam logic [NUM_PIX-1:0] T_LEFT =
    256'h0000_0000_0000_0200_0600_0E00_1E00_3FFC_1E00_0E00_0600_0200_0000_0000_0000_0000;
  localparam logic [NUM_PIX-1:0] T_DOWN =
    256'h0000_0000_0100_0100_0100_0100_0100_0100_0100_1FF0_0FE0_07C0_0380_0100_0000_0000;
  localparam logic [NUM_PIX-1:0] T_UPRIGHT =
    256'h0000_0000_01FC_00FC_007C_003C_005C_008C_0104_0200_0400_0800_1000_2000_0000_0000;
  localparam logic [NUM_PIX-1:0] T_DOWNRIGHT =
    256'h0000_0000_2000_1000_0800_0400_0200_0104_008C_005C_003C_007C_00FC_01FC_0000_0000;
  localparam logic [NUM_PIX-1:0] T_RIGHT =
    256'h0000_0000_0000_0040_0060_0070_0078_3FFC_0078_0070_0060_0040_0000_0000_0000_0000;

  localparam logic [NUM_CLASSES-1:0][NUM_PIX-1:0] TEMPLATES = {
    T_RIGHT, T_DOWNRIGHT, T_UPRIGHT, T_DOWN, T_LEFT, T_LEFTDOWN, T_UPLEFT, T_UP
  };

endpackage

// File: rtl/arrow_neuron_main_if.sv
// Image-in / class-out bundle between the image source and the classifier.
interface arrow_neuron_main_if;
  import arrow_pkg::*;

  logic [NUM_PIX-1:0]     pixel_vector;
  logic [NUM_CLASSES-1:0] neuron_out;

  modport master (output pixel_vector, input neuron_out);
  modport slave  (input pixel_vector, output neuron_out);
endinterface

// File: rtl/arrow_neuron.sv
// One template-matching neuron: +1 per set pixel on the template, -1 per set pixel off it.
module arrow_neuron
  import arrow_pkg::*;
(
  input  logic [NUM_PIX-1:0]        pix,
  input  logic [NUM_PIX-1:0]        template,
  output logic signed [SCORE_W-1:0] score_c
);

  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] miss_cnt;

  always_comb begin
    match_cnt = '0;
    miss_cnt  = '0;
    for (int i = 0; i < int'(NUM_PIX); i++) begin
      match_cnt = match_cnt + CNT_W'(pix[i] & template[i]);
      miss_cnt  = miss_cnt + CNT_W'(pix[i] & ~template[i]);
    end
    score_c = $signed(SCORE_W'(match_cnt)) - $signed(SCORE_W'(miss_cnt));
  end

endmodule

// File: rtl/arrow_neuron_main.sv
// Three-stage arrow glyph classifier: image reg -> eight score regs -> one-hot argmax reg.
// Optional ARROW_REJECT_EN zeroes the output when the best score is not positive.
module arrow_neuron_main
  import arrow_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  arrow_neuron_main_if.slave  bus
);

  logic [NUM_PIX-1:0]        pix_q;
  logic signed [SCORE_W-1:0] score_c [NUM_CLASSES];
  logic signed [SCORE_W-1:0] score_q [NUM_CLASSES];
  logic signed [SCORE_W-1:0] best_c;
  logic [IDX_W-1:0]          best_idx_c;
  logic [NUM_CLASSES-1:0]    win_c;

  for (genvar k = 0; k < int'(NUM_CLASSES); k++) begin : g_neuron
    arrow_neuron u_neuron (
      .pix      (pix_q),
      .template (TEMPLATES[k]),
      .score_c  (score_c[k])
    );
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_c     = score_q[0];
    best_idx_c = '0;
    for (int k = 1; k < int'(NUM_CLASSES); k++) begin
      if (score_q[k] > best_c) begin
        best_c     = score_q[k];
        best_idx_c = IDX_W'(k);
      end
    end
    win_c             = '0;
    win_c[best_idx_c] = 1'b1;
`ifdef ARROW_REJECT_EN
    if (best_c[SCORE_W-1] || (best_c == '0)) begin
      win_c = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q          <= '0;
      bus.neuron_out <= '0;
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        score_q[k] <= '0;
      end
    end else begin
      pix_q          <= bus.pixel_vector;
      bus.neuron_out <= win_c;
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        score_q[k] <= score_c[k];
      end
    end
  end

endmodule

// File: tb/tb_arrow_neuron_main.sv
// Directed + randomized bench for arrow_neuron_main against a pixel-walking reference model.
module tb_arrow_neuron_main;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [15:0]  tmpl [8][16];
  logic [7:0]   exp_q [$];
  logic [7:0]   exp_v;
  logic [255:0] img;

  always #5 clk = ~clk;

  arrow_neuron_main_if bus ();

  arrow_neuron_main dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [255:0] to_img(int k);
    logic [255:0] v;
    for (int r = 0; r < 16; r++) v[255-16*r -: 16] = tmpl[k][r];
    return v;
  endfunction

  // Score each class pixel by pixel, pick the first maximum.
  function automatic logic [7:0] model(logic [255:0] im);
    int best;
    int best_k;
    int s;
    logic p;
    logic t;
    best = -1000;
    best_k = 0;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          p = im[255 - 16*r - c];
          t = tmpl[k][r][15 - c];
          if (p) s = t ? s + 1 : s - 1;
        end
      end
      if (s > best) begin
        best = s;
        best_k = k;
      end
    end
`ifdef ARROW_REJECT_EN
    if (best <= 0) return 8'h00;
`endif
    return 8'(1 << best_k);
  endfunction

  function automatic logic [255:0] rand_img();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(string tag, logic [7:0] got, logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Present one image for one edge; compare the result of the image three edges back.
  task automatic step(string tag, logic [255:0] im);
    bus.pixel_vector = im;
    exp_q.push_back(model(im));
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      exp_v = exp_q.pop_front();
      check(tag, bus.neuron_out, exp_v);
    end
  endtask

  initial begin
    tmpl[0] = '{16'h0000,16'h0000,16'h0100,16'h0380,16'h07C0,16'h0FE0,16'h1FF0,16'h0100,
                16'h0100,16'h0100,16'h0100,16'h0100,16'h0100,16'h0100,16'h0000,16'h0000};
    tmpl[1] = '{16'h0000,16'h0000,16'h3F80,16'h3F00,16'h3E00,16'h3C00,16'h3A00,16'h3100,
                16'h2080,16'h0040,16'h0020,16'h0010,16'h0008,16'h0004,16'h0000,16'h0000};
    tmpl[2] = '{16'h0000,16'h0000,16'h0004,16'h0008,16'h0010,16'h0020,16'h0040,16'h2080,
                16'h3100,16'h3A00,16'h3C00,16'h3E00,16'h3F00,16'h3F80,16'h0000,16'h0000};
    tmpl[3] = '{16'h0000,16'h0000,16'h0000,16'h0200,16'h0600,16'h0E00,16'h1E00,16'h3FFC,
                16'h1E00,16'h0E00,16'h0600,16'h0200,16'h0000,16'h0000,16'h0000,16'h0000};
    tmpl[4] = '{16'h0000,16'h0000,16'h0100,16'h0100,16'h0100,16'h0100,16'h0100,16'h0100,
                16'h0100,16'h1FF0,16'h0FE0,16'h07C0,16'h0380,16'h0100,16'h0000,16'h0000};
    tmpl[5] = '{16'h0000,16'h0000,16'h01FC,16'h00FC,16'h007C,16'h003C,16'h005C,16'h008C,
                16'h0104,16'h0200,16'h0400,16'h0800,16'h1000,16'h2000,16'h0000,16'h0000};
    tmpl[6] = '{16'h0000,16'h0000,16'h2000,16'h1000,16'h0800,16'h0400,16'h0200,16'h0104,
                16'h008C,16'h005C,16'h003C,16'h007C,16'h00FC,16'h01FC,16'h0000,16'h0000};
    tmpl[7] = '{16'h0000,16'h0000,16'h0000,16'h0040,16'h0060,16'h0070,16'h0078,16'h3FFC,
                16'h0078,16'h0070,16'h0060,16'h0040,16'h0000,16'h0000,16'h0000,16'h0000};

    rst = 1'b1;
    bus.pixel_vector = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", bus.neuron_out, 8'h00);
    rst = 1'b0;

    // Each template held five cycles; steady state must be the matching one-hot.
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 5; n++) step($sformatf("hold_k%0d", k), to_img(k));
    end
    check("right_literal", bus.neuron_out, 8'h80);

    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) step($sformatf("stream_k%0d", k), to_img(k));
    end

    for (int n = 0; n < 4; n++) step("all_zero", '0);
`ifdef ARROW_REJECT_EN
    check("all_zero_literal", bus.neuron_out, 8'h00);
`else
    check("all_zero_literal", bus.neuron_out, 8'h01);
`endif

    img = to_img(0);
    img[255] = 1'b1;
    for (int n = 0; n < 4; n++) step("up_stray", img);
    check("up_stray_literal", bus.neuron_out, 8'h01);

    for (int n = 0; n < 4; n++) step("all_ones", '1);

    // Reset with LEFT images in flight: output clears, later output follows only new images.
    step("pre_rst_left", to_img(3));
    step("pre_rst_left", to_img(3));
    bus.pixel_vector = to_img(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_midstream", bus.neuron_out, 8'h00);
    exp_q.delete();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) step("post_rst_up", to_img(0));
    check("post_rst_literal", bus.neuron_out, 8'h01);

    // Noisy templates: a few random pixel flips on a random class.
    for (int n = 0; n < 40; n++) begin
      img = to_img(int'($urandom_range(0, 7)));
      for (int f = 0; f < int'($urandom_range(0, 12)); f++) img[$urandom_range(0, 255)] ^= 1'b1;
      step("rand_noisy", img);
    end

    for (int n = 0; n < 20; n++) step("rand_full", rand_img());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
